cpu_mem_resp: RTL and testbench
===============================

CPU_MEM_RESP -- requirements
Module: cpu_mem_resp

Interface
REQ-001 Parameter: WAIT_STATES, default 2, number of clk edges between address latch and data-ready.
REQ-002 Parameter: DEPTH, default 256, memory size in bytes (8-bit address).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_cycle  input  1  asynchronous, active-high reset.
REQ-005 state  input  8  control FSM state code; this block is the memory responder to it.
REQ-006 addr_in  input  8  bus address (PC, SP or MAR value), sampled on address-latch states.
REQ-007 wdata  input  8  bus write data, sampled on store states.
REQ-008 prog_we  input  1  program-load write strobe.
REQ-009 prog_addr  input  8  program-load address.
REQ-010 prog_data  input  8  program-load data.
REQ-011 instruction  output  8  registered fetched instruction byte, feeds the control FSM.
REQ-012 inst_valid  output  1  one-cycle pulse: instruction updated on the previous edge.
REQ-013 rdata  output  8  registered data-read byte.
REQ-014 rdata_valid  output  1  one-cycle pulse: rdata updated on the previous edge.
REQ-015 ready  output  1  combinational: access latched and wait count complete.
REQ-016 busy  output  1  combinational: access latched, wait count incomplete.
REQ-017 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-018 State codes decoded: ADDR = {0x01 FETCH_PC, 0x0C FETCH_SP, 0x11 SET_ADDR}; WAIT = 0x16; IFETCH = 0x02; DREAD = {0x0A MOV_LOAD, 0x0F RET}; STORE = {0x08 MOV_STORE, 0x0D PC_STORE, 0x13 REG_STORE}; all other codes = no action.
REQ-019 Internal phase FSM, two states: IDLE, PENDING; registers mar[7:0], wait_cnt, addr_valid.
REQ-020 Edge with state in ADDR: mar <= addr_in, wait_cnt <= 0, phase <= PENDING, addr_valid <= 1; re-entry while PENDING restarts the count.
REQ-021 Edge with phase PENDING, state not ADDR, wait_cnt < WAIT_STATES: wait_cnt increments (saturates at WAIT_STATES); WAIT code not required to count.
REQ-022 ready = phase PENDING and wait_cnt == WAIT_STATES; busy = phase PENDING and wait_cnt < WAIT_STATES.
REQ-023 Edge with state IFETCH and ready: instruction <= mem[mar], inst_valid <= 1 next cycle, phase <= IDLE.
REQ-024 Edge with state IFETCH and not ready: instruction <= 0x00 (NOP), inst_valid <= 1, proto_err <= 1, phase <= IDLE.
REQ-025 Edge with state in DREAD: same as REQ-023/024 but targets rdata/rdata_valid; instruction unchanged.
REQ-026 Edge with state in STORE and addr_valid: mem[mar] <= wdata, no wait required, phase unchanged.
REQ-027 STORE with addr_valid == 0: write dropped, proto_err <= 1.
REQ-028 prog_we has priority over STORE at the same edge: prog write performed, bus write dropped, proto_err <= 1; prog_we alone never sets proto_err.
REQ-029 Read and write to same address at same edge: read returns old contents.
REQ-030 inst_valid and rdata_valid deassert on every edge not covered by REQ-023..025.
REQ-031 proto_err clears only on reset.
REQ-032 Address arithmetic 8-bit; no wrap logic needed, addresses 0x00..0xFF all valid.

Reset
REQ-033 reset_cycle high: instruction 0x00, rdata 0x00, inst_valid 0, rdata_valid 0, proto_err 0, phase IDLE, mar 0x00, wait_cnt 0, addr_valid 0, immediately without clk.
REQ-034 Memory contents not cleared by reset; reset mid-access abandons the pending access and produces no valid pulse.

Verification
REQ-035 prog-load 0x10 at 0x00; states 0x01(addr_in 0x00),0x16,0x16,0x02 -> ready high in 0x02 cycle, instruction 0x10, inst_valid one pulse, proto_err 0.
REQ-036 States 0x01,0x16,0x02 (one wait only) -> instruction 0x00, inst_valid pulse, proto_err 1 and stays 1.
REQ-037 0x11(addr 0x80), 0x13(wdata 0x5A), then 0x11(addr 0x80),0x16,0x16,0x0A -> rdata 0x5A, rdata_valid pulse, instruction unchanged.
REQ-038 After reset, 0x13 with wdata 0x77 -> mem unchanged, proto_err 1.
REQ-039 prog_we at 0x80 data 0x11 same edge as 0x13 wdata 0x22 (mar 0x80) -> mem[0x80] = 0x11, proto_err 1.
REQ-040 reset_cycle pulsed between 0x16 cycles -> all outputs at reset values asynchronously, memory preserved, next 0x02 yields NOP with proto_err 1.

Source files
------------

// File: rtl/cpu_mem_resp.sv
// Byte-wide memory responder for the CPU control FSM: latches bus addresses, counts
// wait states, and serves instruction fetches, data reads, stores and program loads.
module cpu_mem_resp #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH       = 256
) (
    input  logic       clk,
    input  logic       reset_cycle,
    input  logic [7:0] state,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] instruction,
    output logic       inst_valid,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       ready,
    output logic       busy,
    output logic       proto_err
);

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_STATES);
    localparam logic [DW-1:0]    NOP      = 8'h00;

    localparam logic [7:0] ST_FETCH_PC  = 8'h01;
    localparam logic [7:0] ST_FETCH_SP  = 8'h0C;
    localparam logic [7:0] ST_SET_ADDR  = 8'h11;
    localparam logic [7:0] ST_IFETCH    = 8'h02;
    localparam logic [7:0] ST_MOV_LOAD  = 8'h0A;
    localparam logic [7:0] ST_RET       = 8'h0F;
    localparam logic [7:0] ST_MOV_STORE = 8'h08;
    localparam logic [7:0] ST_PC_STORE  = 8'h0D;
    localparam logic [7:0] ST_REG_STORE = 8'h13;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } phase_t;

    phase_t            phase, phase_nx;
    logic [AW-1:0]     mar, mar_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic              addr_valid, addr_valid_nx;
    logic [DW-1:0]     instruction_nx, rdata_nx;
    logic              inst_valid_nx, rdata_valid_nx, proto_err_nx;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     read_byte;

    logic is_addr, is_ifetch, is_dread, is_store;

    // Control-state decode
    assign is_addr   = state inside {ST_FETCH_PC, ST_FETCH_SP, ST_SET_ADDR};
    assign is_ifetch = (state == ST_IFETCH);
    assign is_dread  = state inside {ST_MOV_LOAD, ST_RET};
    assign is_store  = state inside {ST_MOV_STORE, ST_PC_STORE, ST_REG_STORE};

    assign ready     = (phase == PENDING) && (wait_cnt == WAIT_MAX);
    assign busy      = (phase == PENDING) && (wait_cnt <  WAIT_MAX);
    assign read_byte = mem[mar];

    // Next-state and registered-output computation
    always_comb begin
        phase_nx       = phase;
        mar_nx         = mar;
        wait_cnt_nx    = wait_cnt;
        addr_valid_nx  = addr_valid;
        instruction_nx = instruction;
        rdata_nx       = rdata;
        inst_valid_nx  = 1'b0;
        rdata_valid_nx = 1'b0;
        proto_err_nx   = proto_err;
        mem_we         = 1'b0;
        mem_waddr      = mar;
        mem_wdata      = wdata;

        if (is_addr) begin
            mar_nx        = addr_in;
            wait_cnt_nx   = '0;
            phase_nx      = PENDING;
            addr_valid_nx = 1'b1;
        end else if (phase == PENDING && wait_cnt < WAIT_MAX) begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
        end

        // A fetch or read without a completed access still pulses valid, with a NOP/zero byte
        if (is_ifetch) begin
            instruction_nx = ready ? read_byte : NOP;
            inst_valid_nx  = 1'b1;
            phase_nx       = IDLE;
            if (!ready) proto_err_nx = 1'b1;
        end

        if (is_dread) begin
            rdata_nx       = ready ? read_byte : NOP;
            rdata_valid_nx = 1'b1;
            phase_nx       = IDLE;
            if (!ready) proto_err_nx = 1'b1;
        end

        // Program load wins over a bus store at the same edge
        if (prog_we) begin
            mem_we    = 1'b1;
            mem_waddr = prog_addr;
            mem_wdata = prog_data;
            if (is_store) proto_err_nx = 1'b1;
        end else if (is_store) begin
            if (addr_valid) mem_we = 1'b1;
            else            proto_err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            phase       <= IDLE;
            mar         <= '0;
            wait_cnt    <= '0;
            addr_valid  <= 1'b0;
            instruction <= NOP;
            inst_valid  <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            phase       <= phase_nx;
            mar         <= mar_nx;
            wait_cnt    <= wait_cnt_nx;
            addr_valid  <= addr_valid_nx;
            instruction <= instruction_nx;
            inst_valid  <= inst_valid_nx;
            rdata       <= rdata_nx;
            rdata_valid <= rdata_valid_nx;
            proto_err   <= proto_err_nx;
        end
    end

    // Storage survives reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_cpu_mem_resp.sv
// Scoreboard bench for cpu_mem_resp: directed protocol scenarios followed by random
// control-state traffic, checked against a transaction-level reference model.
module tb_cpu_mem_resp;

    localparam int unsigned WS = 2;

    logic       clk = 1'b0;
    logic       reset_cycle;
    logic [7:0] state, addr_in, wdata, prog_addr, prog_data;
    logic       prog_we;
    logic [7:0] instruction, rdata;
    logic       inst_valid, rdata_valid, ready, busy, proto_err;

    cpu_mem_resp #(.WAIT_STATES(WS), .DEPTH(256)) dut (
        .clk(clk), .reset_cycle(reset_cycle), .state(state), .addr_in(addr_in),
        .wdata(wdata), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .inst_valid(inst_valid), .rdata(rdata),
        .rdata_valid(rdata_valid), .ready(ready), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       bsy;
        logic       perr;
        logic       iv;
        logic       rv;
        logic [7:0] inst;
        logic [7:0] rd;
    } status_t;

    status_t    st_q[$];
    logic [7:0] inst_q[$];
    logic [7:0] rd_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model: an access is "edges since latch"; it is ready once that reaches WS
    bit         m_pend;
    int         m_edges;
    logic [7:0] m_mar;
    bit         m_av, m_perr, m_iv, m_rv;
    logic [7:0] m_inst, m_rd;
    logic [7:0] m_mem [256];

    logic [7:0] codes [16] = '{8'h01, 8'h0C, 8'h11, 8'h16, 8'h16, 8'h16, 8'h16, 8'h02,
                               8'h0A, 8'h0F, 8'h08, 8'h0D, 8'h13, 8'h00, 8'h05, 8'h3C};

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_pend && (m_edges >= int'(WS));
    endfunction

    task automatic model_reset();
        m_pend = 0; m_edges = 0; m_mar = 8'h00; m_av = 0; m_perr = 0;
        m_iv = 0; m_rv = 0; m_inst = 8'h00; m_rd = 8'h00;
    endtask

    task automatic push_status();
        status_t s;
        s.rdy  = m_ready();
        s.bsy  = m_pend && !m_ready();
        s.perr = m_perr;
        s.iv   = m_iv;
        s.rv   = m_rv;
        s.inst = m_inst;
        s.rd   = m_rd;
        st_q.push_back(s);
    endtask

    task automatic model_step(input logic [7:0] st, input logic [7:0] a, input logic [7:0] wd,
                              input logic pwe, input logic [7:0] pa, input logic [7:0] pd);
        bit         rdy      = m_ready();
        logic [7:0] old_byte = m_mem[m_mar];
        logic [7:0] old_mar  = m_mar;
        bit         store    = st inside {8'h08, 8'h0D, 8'h13};
        m_iv = 0;
        m_rv = 0;
        if (st inside {8'h01, 8'h0C, 8'h11}) begin
            m_mar = a; m_pend = 1; m_edges = 0; m_av = 1;
        end else if (m_pend) begin
            m_edges++;
        end
        if (st == 8'h02) begin
            m_inst = rdy ? old_byte : 8'h00;
            m_iv = 1; m_pend = 0;
            if (!rdy) m_perr = 1;
            inst_q.push_back(m_inst);
        end
        if (st inside {8'h0A, 8'h0F}) begin
            m_rd = rdy ? old_byte : 8'h00;
            m_rv = 1; m_pend = 0;
            if (!rdy) m_perr = 1;
            rd_q.push_back(m_rd);
        end
        if (pwe) begin
            m_mem[pa] = pd;
            if (store) m_perr = 1;
        end else if (store) begin
            if (m_av) m_mem[old_mar] = wd;
            else      m_perr = 1;
        end
    endtask

    // One clock cycle of stimulus, applied just after the active edge
    task automatic drive(input logic [7:0] st, input logic [7:0] a = 8'h00,
                         input logic [7:0] wd = 8'h00, input logic pwe = 1'b0,
                         input logic [7:0] pa = 8'h00, input logic [7:0] pd = 8'h00);
        @(posedge clk);
        #1;
        reset_cycle = 1'b0;
        state = st; addr_in = a; wdata = wd;
        prog_we = pwe; prog_addr = pa; prog_data = pd;
        push_status();
        model_step(st, a, wd, pwe, pa, pd);
    endtask

    task automatic check_reset_values();
        chk8("rst_instruction", instruction, 8'h00);
        chk8("rst_rdata", rdata, 8'h00);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_rdata_valid", rdata_valid, 1'b0);
        chk1("rst_proto_err", proto_err, 1'b0);
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, held for one cycle
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_cycle = 1'b1;
        state = 8'h00; prog_we = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        inst_q.delete();
        rd_q.delete();
        push_status();
    endtask

    // Monitor: per-cycle status plus scoreboard pops on every valid pulse
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk1("ready", ready, s.rdy);
                chk1("busy", busy, s.bsy);
                chk1("proto_err", proto_err, s.perr);
                chk1("inst_valid", inst_valid, s.iv);
                chk1("rdata_valid", rdata_valid, s.rv);
                chk8("instruction_hold", instruction, s.inst);
                chk8("rdata_hold", rdata, s.rd);
            end
            if (inst_valid === 1'b1) begin
                if (inst_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL inst_pulse: got unexpected inst_valid, expected none at %0t", $time);
                end else begin
                    chk8("inst_data", instruction, inst_q.pop_front());
                end
            end
            if (rdata_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rdata_pulse: got unexpected rdata_valid, expected none at %0t", $time);
                end else begin
                    chk8("rdata_data", rdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset_cycle = 1'b1;
        state = 8'h00; addr_in = 8'h00; wdata = 8'h00;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        model_reset();
        #1;
        check_reset_values();

        // Preload every byte so no read returns unknown contents
        for (int i = 0; i < 256; i++) begin
            drive(8'h00, 8'h00, 8'h00, 1'b1, 8'(i), (i == 0) ? 8'h10 : 8'($urandom));
        end

        // Fetch with full wait count
        drive(8'h01, 8'h00); drive(8'h16); drive(8'h16); drive(8'h02);
        chk1("fetch_ready", ready, 1'b1);
        drive(8'h00);
        chk8("fetch_inst", instruction, 8'h10);
        chk1("fetch_valid", inst_valid, 1'b1);
        chk1("fetch_perr", proto_err, 1'b0);
        drive(8'h00);
        chk1("fetch_pulse_end", inst_valid, 1'b0);

        // Early fetch yields NOP and sticky error
        drive(8'h01, 8'h00); drive(8'h16); drive(8'h02); drive(8'h00);
        chk8("early_inst", instruction, 8'h00);
        chk1("early_valid", inst_valid, 1'b1);
        chk1("early_perr", proto_err, 1'b1);
        drive(8'h00); drive(8'h00);
        chk1("early_perr_sticky", proto_err, 1'b1);

        // Store then load back; instruction must hold its last fetch
        do_reset();
        drive(8'h01, 8'h00); drive(8'h16); drive(8'h16); drive(8'h02);
        drive(8'h11, 8'h80); drive(8'h13, 8'h00, 8'h5A);
        drive(8'h11, 8'h80); drive(8'h16); drive(8'h16); drive(8'h0A); drive(8'h00);
        chk8("load_rdata", rdata, 8'h5A);
        chk1("load_valid", rdata_valid, 1'b1);
        chk8("load_inst_hold", instruction, 8'h10);
        chk1("load_perr", proto_err, 1'b0);

        // Store without a latched address is dropped
        do_reset();
        drive(8'h13, 8'h00, 8'h77); drive(8'h00);
        chk1("noaddr_perr", proto_err, 1'b1);
        drive(8'h01, 8'h00); drive(8'h16); drive(8'h16); drive(8'h0A); drive(8'h00);
        chk8("noaddr_mem_kept", rdata, 8'h10);

        // Program load collides with bus store
        do_reset();
        drive(8'h11, 8'h80); drive(8'h13, 8'h00, 8'h22, 1'b1, 8'h80, 8'h11); drive(8'h00);
        chk1("collide_perr", proto_err, 1'b1);
        drive(8'h11, 8'h80); drive(8'h16); drive(8'h16); drive(8'h0A); drive(8'h00);
        chk8("collide_mem", rdata, 8'h11);

        // Reset in the middle of a wait abandons the access
        do_reset();
        drive(8'h01, 8'h00); drive(8'h16);
        do_reset();
        drive(8'h16); drive(8'h02); drive(8'h00);
        chk8("midrst_inst", instruction, 8'h00);
        chk1("midrst_perr", proto_err, 1'b1);
        do_reset();
        drive(8'h01, 8'h00); drive(8'h16); drive(8'h16); drive(8'h02); drive(8'h00);
        chk8("midrst_mem_kept", instruction, 8'h10);

        // Random control-state traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                logic [7:0] a, pa;
                a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                pa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                drive(codes[$urandom_range(0, 15)], a, 8'($urandom),
                      ($urandom_range(0, 7) == 0), pa, 8'($urandom));
            end
        end

        drive(8'h00); drive(8'h00);
        @(negedge clk);
        #1;
        checks++;
        if (inst_q.size() != 0 || rd_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d pending entries expected 0/0/0",
                     inst_q.size(), rd_q.size(), st_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
